// File: rtl/systola_pkg.sv
// Shared definitions for the systolic-array input controller.
//   DW_DEF / LANES_DEF / DEPTH_DEF : default element width, lanes per vector, FIFO depth
//   elem_t / vec_t                 : one element and one default-sized row vector
//   lane_delay()                   : extra output delay for a lane (diagonal skew or aligned)
package systola_pkg;

   localparam int DW_DEF    = 8;
   localparam int LANES_DEF = 8;
   localparam int DEPTH_DEF = 16;

   typedef logic [DW_DEF-1:0]    elem_t;
   typedef elem_t [LANES_DEF-1:0] vec_t;

   // Lane k is held back k cycles so the array edge sees a diagonal wavefront.
   function automatic int lane_delay(input int lane, input int skew_en);
      return (skew_en != 0) ? lane : 0;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-length shift register carrying {valid, data} for one lane.
//   clk     : rising-edge clock
//   rst     : synchronous reset, active-high, clears every stage
//   flush   : synchronous clear, same effect as rst on this block
//   i_vld   : valid entering the line
//   i_data  : data entering the line
//   o_vld   : valid leaving the line, DELAY cycles later
//   o_data  : data leaving the line, DELAY cycles later
// DELAY = 0 is a plain wire.
module skew_delay_line #(
   parameter int DW    = 8,
   parameter int DELAY = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          i_vld,
   input  logic [DW-1:0] i_data,
   output logic          o_vld,
   output logic [DW-1:0] o_data
);

   if (DELAY == 0) begin : g_pass
      logic w_unused;
      assign w_unused = clk ^ rst ^ flush;
      assign o_vld    = i_vld;
      assign o_data   = i_data;
   end else begin : g_dly
      logic [DELAY-1:0] r_vld;
      logic [DW-1:0]    r_data [DELAY];

      // Shift valid and data one stage per cycle; reset and flush drop everything in flight
      always_ff @(posedge clk) begin
         if (rst || flush) begin
            r_vld <= '0;
            for (int i = 0; i < DELAY; i++) begin
               r_data[i] <= '0;
            end
         end else begin
            r_vld[0]  <= i_vld;
            r_data[0] <= i_data;
            for (int i = 1; i < DELAY; i++) begin
               r_vld[i]  <= r_vld[i-1];
               r_data[i] <= r_data[i-1];
            end
         end
      end

      assign o_vld  = r_vld[DELAY-1];
      assign o_data = r_data[DELAY-1];
   end

endmodule

// File: rtl/core_input_skew_ctrl.sv
// Input controller for the systolic array: lockstep A/W row-vector FIFOs feeding the array
// edge through an optional per-lane diagonal skew.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   flush          : synchronous clear of FIFO and skew pipes (overflow kept)
//   write, ain,win : push one A and one W vector
//   read           : pop one A and one W vector
//   as, ws         : post-skew lanes to the array edge
//   avld, wvld     : per-lane valid of as / ws
//   aemptys,wemptys: per-lane empty (identical, FIFOs move together)
//   full, level    : FIFO full flag and number of entries held (0..DEPTH)
//   overflow       : sticky, set when a write is dropped; cleared only by rst
module core_input_skew_ctrl
   import systola_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int LANES   = LANES_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter int SKEW_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     write,
   input  logic [LANES*DW-1:0]      ain,
   input  logic [LANES*DW-1:0]      win,
   input  logic                     read,
   output logic [LANES*DW-1:0]      as,
   output logic [LANES*DW-1:0]      ws,
   output logic [LANES-1:0]         avld,
   output logic [LANES-1:0]         wvld,
   output logic [LANES-1:0]         aemptys,
   output logic [LANES-1:0]         wemptys,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [PW:0]            r_wr_ptr;
   logic [PW:0]            r_rd_ptr;
   logic [LANES*DW-1:0]    r_amem [DEPTH];
   logic [LANES*DW-1:0]    r_wmem [DEPTH];
   logic [LANES*DW-1:0]    r_s0_a;
   logic [LANES*DW-1:0]    r_s0_w;
   logic                   r_s0_vld;
   logic                   r_ovf;

   logic                   w_empty;
   logic                   w_full;
   logic                   w_pop;
   logic                   w_push;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                    (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
   // A pop frees a slot in the same cycle, so write+read while full is accepted.
   // No empty bypass: a pop only ever sees entries stored on an earlier edge.
   assign w_pop   = read && !w_empty && !rst && !flush;
   assign w_push  = write && (!w_full || w_pop) && !rst && !flush;

   assign full     = w_full;
   assign level    = r_wr_ptr - r_rd_ptr;
   assign aemptys  = {LANES{w_empty}};
   assign wemptys  = {LANES{w_empty}};
   assign overflow = r_ovf;

   // Vector storage; contents need no reset because the pointers define what is valid
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_amem[r_wr_ptr[PW-1:0]] <= ain;
         r_wmem[r_wr_ptr[PW-1:0]] <= win;
      end else begin
         r_amem[r_wr_ptr[PW-1:0]] <= r_amem[r_wr_ptr[PW-1:0]];
         r_wmem[r_wr_ptr[PW-1:0]] <= r_wmem[r_wr_ptr[PW-1:0]];
      end
   end

   // Pointer, sticky overflow and stage-0 output register update
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= 1'b0;
         r_s0_vld <= 1'b0;
         r_s0_a   <= '0;
         r_s0_w   <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_s0_vld <= 1'b0;
         r_s0_a   <= '0;
         r_s0_w   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         if (write && w_full && !w_pop) begin
            r_ovf <= 1'b1;
         end
         // A read on empty launches a zero, invalid slot into the skew pipes.
         r_s0_vld <= w_pop;
         r_s0_a   <= w_pop ? r_amem[r_rd_ptr[PW-1:0]] : '0;
         r_s0_w   <= w_pop ? r_wmem[r_rd_ptr[PW-1:0]] : '0;
      end
   end

   // Per-lane skew: lane k leaves stage 0 and waits k more cycles when skew is enabled.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam int LD = lane_delay(k, SKEW_EN);

      skew_delay_line #(.DW(DW), .DELAY(LD)) u_a_dly (
         .clk    (clk),
         .rst    (rst),
         .flush  (flush),
         .i_vld  (r_s0_vld),
         .i_data (r_s0_a[k*DW +: DW]),
         .o_vld  (avld[k]),
         .o_data (as[k*DW +: DW])
      );

      skew_delay_line #(.DW(DW), .DELAY(LD)) u_w_dly (
         .clk    (clk),
         .rst    (rst),
         .flush  (flush),
         .i_vld  (r_s0_vld),
         .i_data (r_s0_w[k*DW +: DW]),
         .o_vld  (wvld[k]),
         .o_data (ws[k*DW +: DW])
      );
   end

endmodule

// File: tb/tb_core_input_skew_ctrl.sv
// Self-checking bench for core_input_skew_ctrl. Two instances share the stimulus: the default
// 8x8 skewed configuration and a 4x16 aligned one. The reference model keeps the FIFO as a
// queue and records what was popped on each clock edge; lane k of the output after edge n is
// the pop of edge n-k (or n when aligned), unless a reset/flush has happened since.
module tb_core_input_skew_ctrl;

   logic        clk = 1'b0;
   logic        rst, flush, write, read;
   logic [63:0] ain, win;

   logic [63:0] as_a, ws_a, as_b, ws_b;
   logic [7:0]  avld_a, wvld_a, ae_a, we_a;
   logic [3:0]  avld_b, wvld_b, ae_b, we_b;
   logic        full_a, full_b, ovf_a, ovf_b;
   logic [4:0]  lvl_a, lvl_b;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [63:0] qa[$];
   logic [63:0] qw[$];
   bit          popv [4096];
   logic [63:0] popa [4096];
   logic [63:0] popw [4096];
   int          n = 0;
   int          last_clr = 0;
   bit          ovf_m = 1'b0;
   int          sel = 0;
   int          m_lanes = 8;
   int          m_dw = 8;
   bit          m_skew = 1'b1;

   always #5 clk = ~clk;

   core_input_skew_ctrl #(.DW(8), .LANES(8), .DEPTH(16), .SKEW_EN(1)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .write(write), .ain(ain), .win(win), .read(read),
      .as(as_a), .ws(ws_a), .avld(avld_a), .wvld(wvld_a), .aemptys(ae_a), .wemptys(we_a),
      .full(full_a), .level(lvl_a), .overflow(ovf_a)
   );

   core_input_skew_ctrl #(.DW(16), .LANES(4), .DEPTH(16), .SKEW_EN(0)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .write(write), .ain(ain), .win(win), .read(read),
      .as(as_b), .ws(ws_b), .avld(avld_b), .wvld(wvld_b), .aemptys(ae_b), .wemptys(we_b),
      .full(full_b), .level(lvl_b), .overflow(ovf_b)
   );

   function automatic logic [63:0] rv();
      return {$urandom(), $urandom()};
   endfunction

   // lane k = k*16 + base*inc, eight 8-bit lanes
   function automatic logic [63:0] ramp(input int base, input int inc);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 8; k++) begin
         v[k*8 +: 8] = 8'(k*16 + base*inc);
      end
      return v;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // apply one clock edge to the model using the inputs currently driven
   task automatic model_edge();
      bit fullb, popb;
      n++;
      popv[n] = 1'b0;
      popa[n] = '0;
      popw[n] = '0;
      if (rst) begin
         qa.delete();
         qw.delete();
         ovf_m    = 1'b0;
         last_clr = n;
      end else if (flush) begin
         qa.delete();
         qw.delete();
         last_clr = n;
      end else begin
         fullb = (qa.size() == 16);
         popb  = read && (qa.size() != 0);
         if (popb) begin
            popv[n] = 1'b1;
            popa[n] = qa.pop_front();
            popw[n] = qw.pop_front();
         end
         if (write && (!fullb || popb)) begin
            qa.push_back(ain);
            qw.push_back(win);
         end else if (write) begin
            ovf_m = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      logic [63:0] ea, ew, lm, emask, lvl_e;
      logic [7:0]  ev;
      int          m;
      ea = '0;
      ew = '0;
      ev = '0;
      lm = (64'd1 << m_dw) - 64'd1;
      for (int k = 0; k < m_lanes; k++) begin
         m = n - (m_skew ? k : 0);
         if (m > last_clr && popv[m]) begin
            ea    |= popa[m] & (lm << (k*m_dw));
            ew    |= popw[m] & (lm << (k*m_dw));
            ev[k]  = 1'b1;
         end
      end
      emask = (qa.size() == 0) ? ((64'd1 << m_lanes) - 64'd1) : 64'd0;
      lvl_e = 64'(qa.size());
      if (sel == 0) begin
         check("a_as",       as_a,              ea);
         check("a_ws",       ws_a,              ew);
         check("a_avld",     {56'd0, avld_a},   {56'd0, ev});
         check("a_wvld",     {56'd0, wvld_a},   {56'd0, ev});
         check("a_aemptys",  {56'd0, ae_a},     emask);
         check("a_wemptys",  {56'd0, we_a},     emask);
         check("a_level",    {59'd0, lvl_a},    lvl_e);
         check("a_full",     {63'd0, full_a},   64'(qa.size() == 16));
         check("a_overflow", {63'd0, ovf_a},    {63'd0, ovf_m});
      end else begin
         check("b_as",       as_b,              ea);
         check("b_ws",       ws_b,              ew);
         check("b_avld",     {60'd0, avld_b},   {56'd0, ev});
         check("b_wvld",     {60'd0, wvld_b},   {56'd0, ev});
         check("b_aemptys",  {60'd0, ae_b},     emask);
         check("b_wemptys",  {60'd0, we_b},     emask);
         check("b_level",    {59'd0, lvl_b},    lvl_e);
         check("b_full",     {63'd0, full_b},   64'(qa.size() == 16));
         check("b_overflow", {63'd0, ovf_b},    {63'd0, ovf_m});
      end
   endtask

   task automatic step(input bit w, input bit r, input bit f, input bit rs,
                       input logic [63:0] a, input logic [63:0] b);
      write = w;
      read  = r;
      flush = f;
      rst   = rs;
      ain   = a;
      win   = b;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      write = 1'b0;
      read  = 1'b0;
      ain   = '0;
      win   = '0;

      // reset state of the 8x8 skewed instance
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);

      // single vector of ones walks out diagonally
      step(1'b1, 1'b0, 1'b0, 1'b0, {8{8'h01}}, rv());
      repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, rv(), rv());
      step(1'b0, 1'b1, 1'b0, 1'b0, rv(), rv());
      repeat (9) step(1'b0, 1'b0, 1'b0, 1'b0, rv(), rv());

      // streaming ramps: first write+read on empty only pushes, then level holds at 1
      step(1'b1, 1'b1, 1'b0, 1'b0, ramp(0, 1), ramp(0, 2));
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, ramp(i, 1), ramp(i, 2));
      end
      step(1'b0, 1'b1, 1'b0, 1'b0, rv(), rv());
      repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, rv(), rv());

      // fill to full, dropped write sets overflow, write+read while full is accepted
      repeat (16) step(1'b1, 1'b0, 1'b0, 1'b0, rv(), rv());
      step(1'b1, 1'b0, 1'b0, 1'b0, rv(), rv());
      step(1'b1, 1'b1, 1'b0, 1'b0, rv(), rv());
      repeat (16) step(1'b0, 1'b1, 1'b0, 1'b0, rv(), rv());
      repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, rv(), rv());

      // read on empty, then write+read on empty
      step(1'b0, 1'b1, 1'b0, 1'b0, rv(), rv());
      step(1'b1, 1'b1, 1'b0, 1'b0, rv(), rv());
      step(1'b0, 1'b1, 1'b0, 1'b0, rv(), rv());
      repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, rv(), rv());

      // flush with 5 entries queued and the skew pipe part-way through a diagonal
      repeat (8) step(1'b1, 1'b0, 1'b0, 1'b0, rv(), rv());
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, rv(), rv());
      step(1'b1, 1'b1, 1'b1, 1'b0, rv(), rv());
      repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, rv(), rv());

      // random traffic with occasional flushes
      repeat (150) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 24) == 0), 1'b0, rv(), rv());
      end
      repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, rv(), rv());

      // 4x16 aligned instance
      sel     = 1;
      m_lanes = 4;
      m_dw    = 16;
      m_skew  = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0);
      repeat (40) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, rv(), rv());
      end
      repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, rv(), rv());
      step(1'b0, 1'b1, 1'b0, 1'b0, rv(), rv());
      // reset mid-stream while a read is in progress
      step(1'b1, 1'b1, 1'b0, 1'b1, rv(), rv());
      repeat (30) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, rv(), rv());
      end
      repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0, rv(), rv());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
